// File: rtl/rw_cmd_pkg.sv
// Shared types and defaults for the read/write command sequencer.
// Holds the FSM state encoding, the default command codes and sizing helpers.
package rw_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_e;

  // Operation type, used for the round-robin memory and for scoreboarding.
  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } op_e;

  localparam logic [2:0] CMD_IDLE_DEF = 3'b111;
  localparam logic [2:0] CMD_WR0_DEF  = 3'b011;
  localparam logic [2:0] CMD_WRN_DEF  = 3'b101;
  localparam logic [2:0] CMD_RD_DEF   = 3'b110;

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width of the phase counter; a single-cycle op still gets a 1-bit counter.
  function automatic int phase_width(input int wr_len, input int rd_len);
    int w;
    w = $clog2(max(wr_len, rd_len));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rw_cmd_seq_if.sv
// Request/command bus between the request logic (master) and the sequencer (slave).
// CW must equal rw_cmd_pkg::phase_width(WR_LEN, RD_LEN) of the attached sequencer.
interface rw_cmd_seq_if #(
  parameter int CMD_W = 3,
  parameter int CW    = 1
);

  logic             wr_req;
  logic             rd_req;
  logic             wr_ack;
  logic             rd_ack;
  logic [CMD_W-1:0] cmd;
  logic             busy;
  logic [CW-1:0]    phase;
  logic             wr_done;
  logic             rd_done;
  logic             rd_abort;

  modport master (
    output wr_req, rd_req,
    input  wr_ack, rd_ack, cmd, busy, phase, wr_done, rd_done, rd_abort
  );

  modport slave (
    input  wr_req, rd_req,
    output wr_ack, rd_ack, cmd, busy, phase, wr_done, rd_done, rd_abort
  );

endinterface

// File: rtl/rw_cmd_seq.sv
// Read/write command sequencer: arbitrates level requests and drives a registered
// command bus for WR_LEN/RD_LEN cycles, with write preemption and back-to-back issue.
module rw_cmd_seq
  import rw_cmd_pkg::*;
#(
  parameter int               CMD_W      = 3,
  parameter int               WR_LEN     = 2,
  parameter int               RD_LEN     = 2,
  parameter logic [CMD_W-1:0] CMD_IDLE   = CMD_W'(CMD_IDLE_DEF),
  parameter logic [CMD_W-1:0] CMD_WR0    = CMD_W'(CMD_WR0_DEF),
  parameter logic [CMD_W-1:0] CMD_WRN    = CMD_W'(CMD_WRN_DEF),
  parameter logic [CMD_W-1:0] CMD_RD     = CMD_W'(CMD_RD_DEF),
  parameter bit               WR_PRIO    = 1'b1,
  parameter bit               RD_PREEMPT = 1'b1
) (
  input logic         clk,
  input logic         rst,
  rw_cmd_seq_if.slave bus
);

  localparam int            CW      = phase_width(WR_LEN, RD_LEN);
  localparam logic [CW-1:0] WR_LAST = CW'(WR_LEN - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(RD_LEN - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  op_e              r_rr_last;
  op_e              w_rr_nxt;
  logic [CMD_W-1:0] r_cmd;
  logic [CMD_W-1:0] w_cmd_nxt;
  logic             r_busy;
  logic [CW-1:0]    r_phase;
  logic [CW-1:0]    w_phase_nxt;

  logic w_wr_last;
  logic w_rd_last;
  logic w_accept;
  logic w_preempt;
  logic w_grant_wr;
  logic w_grant_rd;

  assign w_wr_last = (r_state == ST_WR) && (r_phase == WR_LAST);
  assign w_rd_last = (r_state == ST_RD) && (r_phase == RD_LAST);
  assign w_accept  = (r_state == ST_IDLE) || w_wr_last || w_rd_last;

  // NOTE: non-blocking assignments for every register, so all flops sample the
  // same pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // one unassigned and no latch can be inferred.
    w_state_nxt = r_state;
    w_phase_nxt = r_phase + 1'b1;
    w_cmd_nxt   = r_cmd;
    w_rr_nxt    = r_rr_last;
    w_grant_wr  = 1'b0;
    w_grant_rd  = 1'b0;
    w_preempt   = 1'b0;

    if (w_accept) begin
      if (bus.wr_req && bus.rd_req) begin
        if (WR_PRIO || (r_rr_last == OP_RD)) w_grant_wr = 1'b1;
        else                                 w_grant_rd = 1'b1;
      end else begin
        w_grant_wr = bus.wr_req;
        w_grant_rd = bus.rd_req;
      end
    end else if (RD_PREEMPT && (r_state == ST_RD) && bus.wr_req) begin
      // Outside an accept point RD is never on its last phase, so this truncates it.
      w_preempt  = 1'b1;
      w_grant_wr = 1'b1;
    end

    if (w_grant_wr) begin
      w_state_nxt = ST_WR;
      w_phase_nxt = '0;
      w_cmd_nxt   = CMD_WR0;
      w_rr_nxt    = OP_WR;
    end else if (w_grant_rd) begin
      w_state_nxt = ST_RD;
      w_phase_nxt = '0;
      w_cmd_nxt   = CMD_RD;
      w_rr_nxt    = OP_RD;
    end else if (w_accept) begin
      w_state_nxt = ST_IDLE;
      w_phase_nxt = '0;
      w_cmd_nxt   = CMD_IDLE;
    end else if (r_state == ST_WR) begin
      w_cmd_nxt = CMD_WRN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd     <= CMD_IDLE;
      r_busy    <= 1'b0;
      r_phase   <= '0;
      r_rr_last <= OP_RD;
    end else begin
      r_cmd     <= w_cmd_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_phase   <= w_phase_nxt;
      r_rr_last <= w_rr_nxt;
    end
  end

  // Handshake pulses are suppressed during reset; an op cut by reset reports nothing.
  assign bus.wr_ack   = !rst && w_grant_wr;
  assign bus.rd_ack   = !rst && w_grant_rd;
  assign bus.wr_done  = !rst && w_wr_last;
  assign bus.rd_done  = !rst && w_rd_last;
  assign bus.rd_abort = !rst && w_preempt;

  assign bus.cmd   = r_cmd;
  assign bus.busy  = r_busy;
  assign bus.phase = r_phase;

endmodule

// File: tb/tb_rw_cmd_seq.sv
// Self-checking bench for rw_cmd_seq: four configurations driven from one vector table,
// plus a round-robin ordering sequence checked against a queue of expected grants.
module tb_rw_cmd_seq;
  import rw_cmd_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic wr_q [4];
  logic rd_q [4];

  // 0: defaults, 1: round-robin without preemption, 2: RD_LEN=4, 3: WR_LEN=RD_LEN=1
  rw_cmd_seq_if #(.CMD_W(3), .CW(1)) if0 ();
  rw_cmd_seq_if #(.CMD_W(3), .CW(1)) if1 ();
  rw_cmd_seq_if #(.CMD_W(3), .CW(2)) if2 ();
  rw_cmd_seq_if #(.CMD_W(3), .CW(1)) if3 ();

  assign if0.wr_req = wr_q[0];
  assign if0.rd_req = rd_q[0];
  assign if1.wr_req = wr_q[1];
  assign if1.rd_req = rd_q[1];
  assign if2.wr_req = wr_q[2];
  assign if2.rd_req = rd_q[2];
  assign if3.wr_req = wr_q[3];
  assign if3.rd_req = rd_q[3];

  rw_cmd_seq u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  rw_cmd_seq #(.WR_PRIO(1'b0), .RD_PREEMPT(1'b0)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  rw_cmd_seq #(.RD_LEN(4)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
  rw_cmd_seq #(.WR_LEN(1), .RD_LEN(1)) u_dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  // Output word: {cmd, busy, phase[1:0], wr_ack, rd_ack, wr_done, rd_done, rd_abort}
  typedef struct {
    int          dut;
    logic        rst;
    logic        wr;
    logic        rd;
    logic [10:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    logic [10:0] exp;
    string       name;
  } sb_t;

  vec_t vecs [$];
  sb_t  sb_q [$];
  op_e  op_q [$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input int d, input logic r, input logic w, input logic rd,
                     input logic [2:0] c, input logic b, input logic [1:0] p,
                     input logic [4:0] pulses, input string n);
    vec_t v;
    v.dut  = d;
    v.rst  = r;
    v.wr   = w;
    v.rd   = rd;
    v.exp  = {c, b, p, pulses};
    v.name = n;
    vecs.push_back(v);
  endtask

  function automatic logic [10:0] sample(input int d);
    case (d)
      0:       return {if0.cmd, if0.busy, 1'b0, if0.phase, if0.wr_ack, if0.rd_ack,
                       if0.wr_done, if0.rd_done, if0.rd_abort};
      1:       return {if1.cmd, if1.busy, 1'b0, if1.phase, if1.wr_ack, if1.rd_ack,
                       if1.wr_done, if1.rd_done, if1.rd_abort};
      2:       return {if2.cmd, if2.busy, if2.phase, if2.wr_ack, if2.rd_ack,
                       if2.wr_done, if2.rd_done, if2.rd_abort};
      default: return {if3.cmd, if3.busy, 1'b0, if3.phase, if3.wr_ack, if3.rd_ack,
                       if3.wr_done, if3.rd_done, if3.rd_abort};
    endcase
  endfunction

  initial begin
    logic wa;
    logic ra;
    int   got;
    op_e  exp_op;
    op_e  act_op;
    sb_t  s;

    for (int i = 0; i < 4; i++) begin
      wr_q[i] = 1'b0;
      rd_q[i] = 1'b0;
    end

    // pulses = {wr_ack, rd_ack, wr_done, rd_done, rd_abort}
    // reset held three cycles
    add(0, 1, 0, 0, 3'b111, 0, 2'd0, 5'b00000, "rst_hold0");
    add(0, 1, 0, 0, 3'b111, 0, 2'd0, 5'b00000, "rst_hold1");
    add(0, 1, 0, 0, 3'b111, 0, 2'd0, 5'b00000, "rst_hold2");
    // single write, defaults
    add(0, 0, 0, 0, 3'b111, 0, 2'd0, 5'b00000, "idle");
    add(0, 0, 1, 0, 3'b111, 0, 2'd0, 5'b10000, "wr_acc");
    add(0, 0, 0, 0, 3'b011, 1, 2'd0, 5'b00000, "wr_p0");
    add(0, 0, 0, 0, 3'b101, 1, 2'd1, 5'b00100, "wr_p1");
    add(0, 0, 0, 0, 3'b111, 0, 2'd0, 5'b00000, "wr_end");
    // write priority, back-to-back read, write accepted on last read cycle
    add(0, 0, 1, 1, 3'b111, 0, 2'd0, 5'b10000, "prio_wr");
    add(0, 0, 0, 1, 3'b011, 1, 2'd0, 5'b00000, "prio_p0");
    add(0, 0, 0, 1, 3'b101, 1, 2'd1, 5'b01100, "b2b_rd");
    add(0, 0, 0, 0, 3'b110, 1, 2'd0, 5'b00000, "b2b_rd_p0");
    add(0, 0, 1, 0, 3'b110, 1, 2'd1, 5'b10010, "rd_last_wr");
    add(0, 0, 0, 0, 3'b011, 1, 2'd0, 5'b00000, "b2b_wr_p0");
    add(0, 0, 0, 0, 3'b101, 1, 2'd1, 5'b00100, "b2b_wr_p1");
    add(0, 0, 0, 0, 3'b111, 0, 2'd0, 5'b00000, "b2b_idle");
    // RD_LEN=4: preemption at phase 1, then a full read
    add(2, 0, 0, 1, 3'b111, 0, 2'd0, 5'b01000, "rd4_acc");
    add(2, 0, 0, 0, 3'b110, 1, 2'd0, 5'b00000, "rd4_p0");
    add(2, 0, 1, 0, 3'b110, 1, 2'd1, 5'b10001, "preempt");
    add(2, 0, 0, 0, 3'b011, 1, 2'd0, 5'b00000, "pre_wr0");
    add(2, 0, 0, 0, 3'b101, 1, 2'd1, 5'b00100, "pre_wr1");
    add(2, 0, 0, 0, 3'b111, 0, 2'd0, 5'b00000, "pre_idle");
    add(2, 0, 0, 1, 3'b111, 0, 2'd0, 5'b01000, "rd4b_acc");
    add(2, 0, 0, 0, 3'b110, 1, 2'd0, 5'b00000, "rd4b_p0");
    add(2, 0, 0, 0, 3'b110, 1, 2'd1, 5'b00000, "rd4b_p1");
    add(2, 0, 0, 0, 3'b110, 1, 2'd2, 5'b00000, "rd4b_p2");
    add(2, 0, 0, 0, 3'b110, 1, 2'd3, 5'b00010, "rd4b_done");
    add(2, 0, 0, 0, 3'b111, 0, 2'd0, 5'b00000, "rd4b_idle");
    // single-cycle ops alternating every cycle
    add(3, 0, 1, 0, 3'b111, 0, 2'd0, 5'b10000, "l1_wr");
    add(3, 0, 0, 1, 3'b011, 1, 2'd0, 5'b01100, "l1_rd");
    add(3, 0, 1, 0, 3'b110, 1, 2'd0, 5'b10010, "l1_wr2");
    add(3, 0, 0, 1, 3'b011, 1, 2'd0, 5'b01100, "l1_rd2");
    add(3, 0, 0, 0, 3'b110, 1, 2'd0, 5'b00010, "l1_rd_end");
    add(3, 0, 0, 0, 3'b111, 0, 2'd0, 5'b00000, "l1_idle");
    // reset in write phase 1, then a normal read
    add(0, 0, 1, 0, 3'b111, 0, 2'd0, 5'b10000, "rst_wr_acc");
    add(0, 0, 0, 0, 3'b011, 1, 2'd0, 5'b00000, "rst_wr_p0");
    add(0, 1, 0, 0, 3'b101, 1, 2'd1, 5'b00000, "rst_mid");
    add(0, 0, 0, 1, 3'b111, 0, 2'd0, 5'b01000, "rst_rd_acc");
    add(0, 0, 0, 0, 3'b110, 1, 2'd0, 5'b00000, "rst_rd_p0");
    add(0, 0, 0, 0, 3'b110, 1, 2'd1, 5'b00010, "rst_rd_p1");
    add(0, 0, 0, 0, 3'b111, 0, 2'd0, 5'b00000, "rst_idle");

    foreach (vecs[k]) begin
      @(posedge clk);
      #1;
      rst = vecs[k].rst;
      for (int i = 0; i < 4; i++) begin
        wr_q[i] = 1'b0;
        rd_q[i] = 1'b0;
      end
      wr_q[vecs[k].dut] = vecs[k].wr;
      rd_q[vecs[k].dut] = vecs[k].rd;
      s.exp  = vecs[k].exp;
      s.name = vecs[k].name;
      sb_q.push_back(s);
      @(negedge clk);
      s = sb_q.pop_front();
      check(s.name, {5'b0, sample(vecs[k].dut)}, {5'b0, s.exp});
    end

    // Round-robin on dut1: a lone write leaves rr_last=WR, then both requests
    // held (each dropped only the cycle after its ack) must grant RD, WR, RD.
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      wr_q[i] = 1'b0;
      rd_q[i] = 1'b0;
    end
    wr_q[1] = 1'b1;
    @(negedge clk);
    check("rr_prime_ack", {15'b0, if1.wr_ack}, 16'd1);
    @(posedge clk);
    #1;
    wr_q[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    op_q.push_back(OP_RD);
    op_q.push_back(OP_WR);
    op_q.push_back(OP_RD);
    wr_q[1] = 1'b1;
    rd_q[1] = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
      @(negedge clk);
      wa = if1.wr_ack;
      ra = if1.rd_ack;
      if (got > 0) check("rr_no_bubble", {15'b0, if1.busy}, 16'd1);
      if (wa || ra) begin
        check("rr_one_ack", {15'b0, wa & ra}, 16'd0);
        exp_op = op_q.pop_front();
        act_op = wa ? OP_WR : OP_RD;
        check("rr_order", {15'b0, act_op}, {15'b0, exp_op});
        got++;
      end
      @(posedge clk);
      #1;
      wr_q[1] = (got < 3) && !wa;
      rd_q[1] = (got < 3) && !ra;
    end
    if (got < 3) check("rr_timeout", 16'(got), 16'd3);

    wr_q[1] = 1'b0;
    rd_q[1] = 1'b0;
    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
